// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming signed max-pooling over fixed-length vectors, one result per window.
module maxpool_stream #(
  parameter int WIDTH = 8,
  parameter int LENY  = 5,
  parameter int POOL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data_out,
  output logic             m_valid,
  input  logic             m_ready
);
  localparam int IW = LENY > 1 ? $clog2(LENY) : 1;
  localparam int PW = POOL > 1 ? $clog2(POOL) : 1;
  localparam logic [IW-1:0] ILAST = IW'(LENY - 1);
  localparam logic [PW-1:0] WLAST = PW'(POOL - 1);
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] max_q, max_d, m_data_q, m_data_d, cand;
  logic             m_valid_q, m_valid_d, acc, last_idx, close;
  assign s_ready    = (~m_valid_q | m_ready) & ~reset;
  assign m_valid    = m_valid_q;
  assign m_data_out = m_data_q;
  // Window bookkeeping: running max, counters, and the output register that refills without a bubble.
  always_comb begin
    acc       = s_valid & s_ready;
    last_idx  = idx_q == ILAST;
    close     = (win_q == WLAST) | last_idx;
    cand      = (win_q == '0 || $signed(s_data_in) > $signed(max_q)) ? s_data_in : max_q;
    idx_d     = reset ? '0 : acc ? (last_idx ? '0 : idx_q + 1'b1) : idx_q;
    win_d     = reset ? '0 : acc ? (close ? '0 : win_q + 1'b1) : win_q;
    max_d     = reset ? '0 : acc ? cand : max_q;
    m_valid_d = reset ? 1'b0 : (acc & close) ? 1'b1 : (m_ready ? 1'b0 : m_valid_q);
    m_data_d  = reset ? '0 : (acc & close) ? cand : m_data_q;
  end
  // State register.
  always_ff @(posedge clk) begin
    idx_q     <= idx_d;
    win_q     <= win_d;
    max_q     <= max_d;
    m_valid_q <= m_valid_d;
    m_data_q  <= m_data_d;
  end
endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: sample width, signed two's complement.
REQ-002 SHALL provide parameter LENY, default 5: samples per input vector (convolution output length).
REQ-003 SHALL provide parameter POOL, default 2: pooling window size, 1 <= POOL <= LENY.
REQ-004 SHALL provide port clk, input, 1: clock, all state on rising edge.
REQ-005 SHALL provide port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL provide port s_data_in, input, WIDTH: signed input sample from the upstream convolution stage.
REQ-007 SHALL provide port s_valid, input, 1: upstream sample valid.
REQ-008 SHALL provide port s_ready, output, 1: block can accept a sample.
REQ-009 SHALL provide port m_data_out, output, WIDTH: signed pooled result.
REQ-010 SHALL provide port m_valid, output, 1: m_data_out valid.
REQ-011 SHALL provide port m_ready, input, 1: downstream accepts result.

Function
REQ-012 Input transfer SHALL occur only in a cycle with s_valid=1 and s_ready=1; output transfer only with m_valid=1 and m_ready=1.
REQ-013 s_ready SHALL be combinational: s_ready = (~m_valid | m_ready) & ~reset.
REQ-014 Block SHALL keep a sample index idx (0..LENY-1) and a window count win (0..POOL-1), both incremented per accepted sample.
REQ-015 First sample of a window (win=0) SHALL load the running maximum directly; later samples SHALL replace it only if strictly greater (signed compare, full WIDTH, no saturation or truncation).
REQ-016 A window SHALL close on the accepted sample with win=POOL-1 or idx=LENY-1, whichever comes first.
REQ-017 On window close, win SHALL return to 0; if idx=LENY-1, idx SHALL also return to 0 (next vector starts with no gap or idle cycle).
REQ-018 Last window of a vector SHALL be partial when LENY mod POOL != 0; its result is the max of the remaining samples; output count per vector = ceil(LENY/POOL).
REQ-019 Window result SHALL appear on m_data_out with m_valid=1 in the cycle after the closing sample is accepted (latency 1).
REQ-020 While m_valid=1 and m_ready=0, m_data_out and m_valid SHALL hold stable and no input SHALL be accepted.
REQ-021 If m_valid=1, m_ready=1 and a closing sample is accepted in the same cycle, m_valid SHALL stay 1 next cycle with the new result (no bubble).
REQ-022 If m_valid=1, m_ready=1 and no closing sample is accepted, m_valid SHALL drop to 0 next cycle.
REQ-023 Non-closing samples SHALL update only the running maximum and counters, never m_data_out or m_valid.
REQ-024 With POOL=1 every accepted sample SHALL pass through unchanged with latency 1.

Reset
REQ-025 While reset=1: s_ready=0; next cycle m_valid=0, m_data_out=0, idx=0, win=0, running maximum=0.
REQ-026 Reset asserted mid-window or mid-vector SHALL discard the partial window and any unread result; first sample after reset starts a new vector at idx=0.
REQ-027 Reset SHALL take priority over any simultaneous input or output transfer.

Verification (WIDTH=8, LENY=5, POOL=2 unless stated)
REQ-028 Stream 3,-7,5,9,-2 with m_ready=1 -> outputs 3, 9, -2 (partial last window), each one cycle after the closing input.
REQ-029 All-negative: stream -128,-1,-5,-6,-128 -> outputs -1, -5, -128; checks signed compare.
REQ-030 Backpressure: m_ready=0 for 4 cycles after first result -> m_data_out=3 held, s_ready=0 throughout, no sample lost; outputs still 3, 9, -2.
REQ-031 Two vectors back-to-back (1,2,3,4,5 then 10,0,-1,7,7) with continuous s_valid and m_ready=1 -> outputs 2,4,5,10,7,7 with no idle cycle at the vector boundary.
REQ-032 Reset after first two samples of a vector, then stream 3,-7,5,9,-2 -> outputs 3, 9, -2 only; no stale result emitted.
REQ-033 POOL=1, LENY=3: stream 4,-4,0 -> outputs 4,-4,0, latency 1 each.
